// File: rtl/prim_ram_2p_port_adapter.sv
// Host-side adapter for one port of the two-port ECC RAM: credit-gated request
// issue, response FIFO with backpressure, ECC error statistics and protocol checks.
module prim_ram_2p_port_adapter #(
  parameter int SramAw   = 9,
  parameter int Width    = 32,
  parameter int RspDepth = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [SramAw-1:0] req_addr_i,
  input  logic [Width-1:0]  req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [Width-1:0]  rsp_rdata_o,
  output logic [1:0]        rsp_rerror_o,
  output logic              ram_req_o,
  output logic              ram_write_o,
  output logic [SramAw-1:0] ram_addr_o,
  output logic [Width-1:0]  ram_wdata_o,
  input  logic              ram_rvalid_i,
  input  logic [Width-1:0]  ram_rdata_i,
  input  logic [1:0]        ram_rerror_i,
  output logic [7:0]        corr_cnt_o,
  output logic [7:0]        uncorr_cnt_o,
  output logic [SramAw-1:0] err_addr_o,
  output logic              proto_err_o
);

  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int CntW = $clog2(RspDepth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(RspDepth);

  logic [CntW-1:0]   outst;
  logic              issue_rd;
  logic              rsp_pop;

  logic [SramAw-1:0] addr_mem [RspDepth];
  logic [PtrW-1:0]   addr_wptr, addr_rptr;
  logic [CntW-1:0]   addr_cnt;
  logic              addr_empty;
  logic              beat_ok;
  logic [SramAw-1:0] beat_addr;

  logic [Width+1:0]  rsp_mem [RspDepth];
  logic [PtrW-1:0]   rsp_wptr, rsp_rptr;
  logic [CntW-1:0]   rsp_cnt;

  function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CntW-1:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + CntW'(1);
    else if (dec && !inc) res = cnt - CntW'(1);
    return res;
  endfunction

  // Reads are gated by credits so the non-stalling RAM can never overrun the response FIFO.
  always_comb begin
    req_ready_o = !rst_i && (req_write_i || (outst < DepthCnt));
    ram_req_o   = req_valid_i && req_ready_o;
    ram_write_o = req_write_i;
    ram_addr_o  = req_addr_i;
    ram_wdata_o = req_wdata_i;
    issue_rd    = ram_req_o && !req_write_i;
  end

  always_comb begin
    addr_empty  = (addr_cnt == '0);
    beat_ok     = ram_rvalid_i && !addr_empty;
    beat_addr   = addr_mem[addr_rptr];
    rsp_valid_o = (rsp_cnt != '0);
    rsp_pop     = rsp_valid_o && rsp_ready_i;
    {rsp_rerror_o, rsp_rdata_o} = rsp_valid_o ? rsp_mem[rsp_rptr] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (issue_rd) addr_mem[addr_wptr] <= req_addr_i;
    if (beat_ok)  rsp_mem[rsp_wptr]   <= {ram_rerror_i, ram_rdata_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst     <= '0;
      addr_wptr <= '0;
      addr_rptr <= '0;
      addr_cnt  <= '0;
      rsp_wptr  <= '0;
      rsp_rptr  <= '0;
      rsp_cnt   <= '0;
    end else begin
      outst    <= next_cnt(outst, issue_rd, rsp_pop);
      addr_cnt <= next_cnt(addr_cnt, issue_rd, beat_ok);
      rsp_cnt  <= next_cnt(rsp_cnt, beat_ok, rsp_pop);
      if (issue_rd) addr_wptr <= addr_wptr + PtrW'(1);
      if (beat_ok) begin
        addr_rptr <= addr_rptr + PtrW'(1);
        rsp_wptr  <= rsp_wptr + PtrW'(1);
      end
      if (rsp_pop) rsp_rptr <= rsp_rptr + PtrW'(1);
    end
  end

  // A beat with no matching address is dropped and only flags the protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
      err_addr_o   <= '0;
      proto_err_o  <= 1'b0;
    end else begin
      if (ram_rvalid_i && addr_empty) proto_err_o <= 1'b1;
      if (beat_ok) begin
        if (ram_rerror_i[1]) begin
          if (uncorr_cnt_o != 8'hFF) uncorr_cnt_o <= uncorr_cnt_o + 8'd1;
        end else if (ram_rerror_i[0]) begin
          if (corr_cnt_o != 8'hFF) corr_cnt_o <= corr_cnt_o + 8'd1;
        end
        if (ram_rerror_i != 2'b00) err_addr_o <= beat_addr;
      end
    end
  end

endmodule

// File: tb/tb_prim_ram_2p_port_adapter.sv
// Directed self-checking bench for prim_ram_2p_port_adapter against a
// one-cycle-latency RAM model with per-address ECC error flags.
module tb_prim_ram_2p_port_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_rerror;
  logic        ram_req, ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;
  logic [1:0]  ram_rerror;
  logic [7:0]  corr_cnt, uncorr_cnt;
  logic [8:0]  err_addr;
  logic        proto_err;

  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rerror = '0;
  logic        inj_valid = 1'b0;
  logic [31:0] inj_rdata = '0;
  logic [1:0]  inj_rerror = '0;
  logic        err_force_en = 1'b0;
  logic [31:0] ram_model [512];
  logic [1:0]  ram_err [512];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prim_ram_2p_port_adapter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_rerror_o(rsp_rerror),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata),
    .ram_rerror_i(ram_rerror), .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
    .err_addr_o(err_addr), .proto_err_o(proto_err)
  );

  // RAM model: fixed one-cycle read latency, writes land at the clock edge.
  always @(posedge clk) begin
    m_rvalid <= ram_req && !ram_write;
    m_rdata  <= ram_model[ram_addr];
    m_rerror <= err_force_en ? 2'b01 : ram_err[ram_addr];
    if (ram_req && ram_write) ram_model[ram_addr] <= ram_wdata;
  end

  assign ram_rvalid = m_rvalid | inj_valid;
  assign ram_rdata  = inj_valid ? inj_rdata : m_rdata;
  assign ram_rerror = inj_valid ? inj_rerror : m_rerror;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present reads for a fixed number of cycles, counting accepted handshakes.
  task automatic apply_stimulus(input int cycles, input int want,
                                input logic [8:0] base, output int issued);
    logic fire;
    issued = 0;
    for (int c = 0; c < cycles; c++) begin
      req_valid = (issued < want);
      req_write = 1'b0;
      req_addr  = base + 9'(issued);
      #1;
      fire = ram_req;
      tick();
      if (fire) issued++;
    end
    req_valid = 1'b0;
  endtask

  task automatic read_one(input logic [8:0] addr, output logic [31:0] data,
                          output logic [1:0] err);
    int n;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!ram_req && n < 20) begin tick(); n++; end
    if (n >= 20) check_output("read_issue_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    if (n >= 20) check_output("read_rsp_timeout", 0, 1);
    data = rsp_rdata;
    err  = rsp_rerror;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int issued, n_rsp;
    logic fire_req, fire_rsp;
    logic [31:0] d;
    logic [1:0] e;

    for (int i = 0; i < 512; i++) begin
      ram_model[i] = 32'h1000_0000 + 32'(i);
      ram_err[i]   = 2'b00;
    end
    ram_model[9'h010] = 32'hDEAD_BEEF;
    ram_err[9'h005]   = 2'b01;
    ram_err[9'h007]   = 2'b10;

    // Reset values, with a pending request that must not reach the RAM
    req_valid = 1'b1;
    tick(); tick();
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_ram_req", ram_req, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_rdata", rsp_rdata, 0);
    check_output("rst_rsp_rerror", rsp_rerror, 0);
    check_output("rst_counters", {corr_cnt, uncorr_cnt}, 0);
    check_output("rst_err_addr", err_addr, 0);
    check_output("rst_proto_err", proto_err, 0);
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    check_output("post_rst_req_ready", req_ready, 1);

    // Single read of 0x10: response two cycles after issue
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h010; rsp_ready = 1'b1;
    #1;
    check_output("rd1_ram_req", ram_req, 1);
    check_output("rd1_ram_addr", ram_addr, 32'h10);
    tick();
    req_valid = 1'b0;
    check_output("rd1_rsp_not_yet", rsp_valid, 0);
    tick();
    check_output("rd1_rsp_valid", rsp_valid, 1);
    check_output("rd1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_output("rd1_rerror", rsp_rerror, 0);
    tick();
    check_output("rd1_popped", rsp_valid, 0);
    check_output("rd1_counters", {corr_cnt, uncorr_cnt}, 0);

    // Backpressure: 6 reads, only 4 credits
    rsp_ready = 1'b0;
    apply_stimulus(8, 6, 9'h020, issued);
    check_output("bp_pulses", issued, 4);
    check_output("bp_read_blocked", req_ready, 0);
    check_output("bp_rsp_hold_valid", rsp_valid, 1);
    check_output("bp_rsp_hold_data", rsp_rdata, 32'h1000_0020);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1F0; req_wdata = 32'hCAFE_0001;
    #1;
    check_output("bp_write_ready", req_ready, 1);
    check_output("bp_write_req", ram_req, 1);
    tick();
    req_write = 1'b0;
    rsp_ready = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 30 && n_rsp < 6; c++) begin
      req_valid = (issued < 6);
      req_addr  = 9'h020 + 9'(issued);
      #1;
      fire_req = ram_req;
      fire_rsp = rsp_valid;
      if (fire_rsp)
        check_output($sformatf("drain_data%0d", n_rsp), rsp_rdata,
                     32'h1000_0020 + 32'(n_rsp));
      tick();
      if (fire_req) issued++;
      if (fire_rsp) n_rsp++;
    end
    req_valid = 1'b0;
    check_output("drain_count", n_rsp, 6);
    check_output("drain_issued", issued, 6);

    // Write pass-through, then ECC error accounting
    read_one(9'h1F0, d, e);
    check_output("wr_readback", d, 32'hCAFE_0001);
    read_one(9'h005, d, e);
    check_output("corr_rerror", e, 2'b01);
    read_one(9'h007, d, e);
    check_output("uncorr_rerror", e, 2'b10);
    check_output("corr_cnt_1", corr_cnt, 1);
    check_output("uncorr_cnt_1", uncorr_cnt, 1);
    check_output("err_addr_07", err_addr, 32'h7);

    // 300 streaming reads, each correctable: saturation and full throughput
    err_force_en = 1'b1;
    apply_stimulus(300, 300, 9'h000, issued);
    check_output("stream_issued", issued, 300);
    tick(); tick(); tick();
    err_force_en = 1'b0;
    check_output("corr_saturated", corr_cnt, 255);
    check_output("uncorr_unchanged", uncorr_cnt, 1);
    check_output("stream_err_addr", err_addr, 32'd299);
    check_output("stream_drained", rsp_valid, 0);

    // Spurious RAM beat with nothing outstanding
    check_output("proto_pre", proto_err, 0);
    inj_valid = 1'b1; inj_rdata = 32'h5555_AAAA; inj_rerror = 2'b11;
    tick();
    inj_valid = 1'b0;
    check_output("proto_set", proto_err, 1);
    check_output("proto_no_rsp", rsp_valid, 0);
    tick(); tick();
    check_output("proto_sticky", proto_err, 1);
    check_output("proto_no_count", {corr_cnt, uncorr_cnt}, 32'hFF01);

    // Reset with 3 reads outstanding
    rsp_ready = 1'b0;
    apply_stimulus(5, 3, 9'h030, issued);
    check_output("pre_rst_issued", issued, 3);
    check_output("pre_rst_rsp_valid", rsp_valid, 1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_req_ready", req_ready, 0);
    tick();
    check_output("mid_rst_rsp_valid", rsp_valid, 0);
    check_output("mid_rst_counters", {corr_cnt, uncorr_cnt}, 0);
    check_output("mid_rst_err_addr", err_addr, 0);
    check_output("mid_rst_proto", proto_err, 0);
    rst = 1'b0;
    tick();
    check_output("post_rst2_req_ready", req_ready, 1);
    check_output("post_rst2_rsp_valid", rsp_valid, 0);
    apply_stimulus(6, 6, 9'h040, issued);
    check_output("post_rst2_credits", issued, 4);
    check_output("post_rst2_full", req_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
